skolem_sweep_ctrl: RTL and testbench



---
 rtl/skolem_pkg.sv | 30 +++
 rtl/skolem_sweep_cnt.sv | 28 ++
 rtl/skolem_sweep_ctrl.sv | 136 +++++++++++++
 tb/tb_skolem_sweep_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/skolem_pkg.sv
// Shared types for the Skolem-candidate sweep controller: FSM states, the
// default sweep width and the y_out phase selection.
package skolem_pkg;

    localparam int NX_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PH_Y0,
        ST_PH_Y1,
        ST_PH_SK,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        Y_ZERO,
        Y_ONE,
        Y_SKOLEM
    } y_sel_t;

    // Which value each state presents on y_out to the spec evaluator.
    function automatic y_sel_t phase_y_sel(input state_t s);
        case (s)
            ST_PH_Y1: return Y_ONE;
            ST_PH_SK: return Y_SKOLEM;
            default:  return Y_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/skolem_sweep_cnt.sv
// NX-bit assignment counter for the sweep: synchronous clear, increment,
// and a terminal flag. It saturates at all-ones, so it never wraps.
module skolem_sweep_cnt #(
    parameter int NX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [NX-1:0] x,
    output logic          last
);

    assign last = &x;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
        end else if (clr) begin
            x <= '0;
        end else if (inc && !last) begin
            x <= x + NX'(1);
        end
    end

endmodule

// File: rtl/skolem_sweep_ctrl.sv
// Sweeps every x assignment, time-sharing an external spec evaluator across
// y=0, y=1 and y=Skolem(x) to count candidate failures and vacuous points.
module skolem_sweep_ctrl
    import skolem_pkg::*;
#(
    parameter int NX           = NX_DEFAULT,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic [NX-1:0] x_out,
    output logic          y_out,
    input  logic          sk_in,
    input  logic          spec_in,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [NX:0]   fail_cnt,
    output logic [NX:0]   vac_cnt,
    output logic          cex_valid,
    output logic [NX-1:0] cex_x
);

    state_t state_q, state_d;
    logic   s0, s1;
    logic   cnt_clr, cnt_inc, x_last;
    logic   fail, vacuous, accept, cancel;

    skolem_sweep_cnt #(.NX(NX)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .x    (x_out),
        .last (x_last)
    );

    // fail/vacuous are only meaningful while state_q is PH_SK.
    assign fail    = (s0 | s1) & ~spec_in;
    assign vacuous = ~s0 & ~s1;
    assign accept  = (state_q == ST_IDLE) && start && !abort;
    assign cancel  = (state_q != ST_IDLE) && abort;

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    always_comb begin
        case (phase_y_sel(state_q))
            Y_ONE:    y_out = 1'b1;
            Y_SKOLEM: y_out = sk_in;
            default:  y_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block is given a default before the case,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_PH_Y0;
                    cnt_clr = 1'b1;
                end
            end
            ST_PH_Y0: state_d = ST_PH_Y1;
            ST_PH_Y1: state_d = ST_PH_SK;
            ST_PH_SK: begin
                if (x_last || (fail && STOP_ON_FAIL)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_PH_Y0;
                    cnt_inc = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (cancel) begin
            state_d = ST_IDLE;
            cnt_inc = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0        <= 1'b0;
            s1        <= 1'b0;
            pass      <= 1'b0;
            fail_cnt  <= '0;
            vac_cnt   <= '0;
            cex_valid <= 1'b0;
            cex_x     <= '0;
        end else if (cancel) begin
            pass <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        s0        <= 1'b0;
                        s1        <= 1'b0;
                        pass      <= 1'b0;
                        fail_cnt  <= '0;
                        vac_cnt   <= '0;
                        cex_valid <= 1'b0;
                        cex_x     <= '0;
                    end
                end
                ST_PH_Y0: s0 <= spec_in;
                ST_PH_Y1: s1 <= spec_in;
                ST_PH_SK: begin
                    if (fail) begin
                        fail_cnt <= fail_cnt + (NX+1)'(1);
                        if (!cex_valid) begin
                            cex_valid <= 1'b1;
                            cex_x     <= x_out;
                        end
                    end
                    if (vacuous) vac_cnt <= vac_cnt + (NX+1)'(1);
                end
                ST_DONE: pass <= (fail_cnt == '0);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// Directed bench: a parity-style reference function f(x) acts as the spec,
// and the Skolem candidate is f(x) with optional inversions at chosen x.
module tb_skolem_sweep_ctrl;

    localparam int NX = 8;

    logic clk = 1'b0;
    logic rst, start, abort, start_sof;

    logic [NX-1:0] x_out, cex_x, x_sof, cex_x_sof;
    logic          y_out, sk_in, spec_in, busy, done, pass, cex_valid;
    logic          y_sof, sk_sof, spec_sof, busy_sof, done_sof, pass_sof, cex_valid_sof;
    logic [NX:0]   fail_cnt, vac_cnt, fail_cnt_sof, vac_cnt_sof;

    logic       spec_zero;
    logic [8:0] inv_a, inv_b;   // 9'h100 never matches an 8-bit x

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    function automatic logic f_ref(input logic [7:0] x);
        return x[0] ^ x[3] ^ x[6];
    endfunction

    assign sk_in    = f_ref(x_out) ^ (({1'b0, x_out} == inv_a) || ({1'b0, x_out} == inv_b));
    assign spec_in  = spec_zero ? 1'b0 : (y_out == f_ref(x_out));
    assign sk_sof   = f_ref(x_sof) ^ (({1'b0, x_sof} == inv_a) || ({1'b0, x_sof} == inv_b));
    assign spec_sof = spec_zero ? 1'b0 : (y_sof == f_ref(x_sof));

    skolem_sweep_ctrl #(.NX(NX), .STOP_ON_FAIL(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .x_out(x_out), .y_out(y_out), .sk_in(sk_in), .spec_in(spec_in),
        .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
        .vac_cnt(vac_cnt), .cex_valid(cex_valid), .cex_x(cex_x)
    );

    skolem_sweep_ctrl #(.NX(NX), .STOP_ON_FAIL(1'b1)) dut_sof (
        .clk(clk), .rst(rst), .start(start_sof), .abort(1'b0),
        .x_out(x_sof), .y_out(y_sof), .sk_in(sk_sof), .spec_in(spec_sof),
        .busy(busy_sof), .done(done_sof), .pass(pass_sof), .fail_cnt(fail_cnt_sof),
        .vac_cnt(vac_cnt_sof), .cex_valid(cex_valid_sof), .cex_x(cex_x_sof)
    );

    // Raise start for one edge and count edges until done is seen (bounded).
    task automatic run_sweep(input bit sof, output int cycles);
        @(negedge clk);
        if (sof) start_sof = 1'b1;
        else     start     = 1'b1;
        cycles = 0;
        do begin
            @(negedge clk);
            start     = 1'b0;
            start_sof = 1'b0;
            cycles++;
        end while (!(sof ? done_sof : done) && cycles < 2000);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_sof = 1'b0; abort = 1'b0;
        spec_zero = 1'b0; inv_a = 9'h100; inv_b = 9'h100;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        total++; if ({pass, cex_valid, y_out} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {pass, cex_valid, y_out}); else passed++;
        total++; if ({x_out, cex_x} !== 16'h0000) $display("FAIL reset_x: got %h expected 0000", {x_out, cex_x}); else passed++;
        total++; if ({fail_cnt, vac_cnt} !== 18'h0) $display("FAIL reset_cnt: got %h expected 0", {fail_cnt, vac_cnt}); else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_pass();
        int c;
        inv_a = 9'h100; inv_b = 9'h100; spec_zero = 1'b0;
        run_sweep(1'b0, c);
        total++; if (c != 769) $display("FAIL full_latency: got %0d expected 769", c); else passed++;
        @(negedge clk);
        total++; if (done !== 1'b0) $display("FAIL full_done_width: got %b expected 0", done); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL full_busy_after: got %b expected 0", busy); else passed++;
        total++; if (pass !== 1'b1) $display("FAIL full_pass: got %b expected 1", pass); else passed++;
        total++; if (fail_cnt !== 9'd0 || vac_cnt !== 9'd0) $display("FAIL full_counts: got fail=%0d vac=%0d expected 0/0", fail_cnt, vac_cnt); else passed++;
        total++; if (cex_valid !== 1'b0) $display("FAIL full_cex_valid: got %b expected 0", cex_valid); else passed++;
        total++; if (x_out !== 8'hFF) $display("FAIL full_x_hold: got %h expected ff", x_out); else passed++;
    endtask

    task automatic test_counterexamples();
        int c;
        inv_a = 9'h02A; inv_b = 9'h080;
        run_sweep(1'b0, c);
        total++; if (c != 769) $display("FAIL cex_latency: got %0d expected 769", c); else passed++;
        @(negedge clk);
        total++; if (fail_cnt !== 9'd2) $display("FAIL cex_fail_cnt: got %0d expected 2", fail_cnt); else passed++;
        total++; if (cex_valid !== 1'b1 || cex_x !== 8'h2A) $display("FAIL cex_first: got v=%b x=%h expected 1/2a", cex_valid, cex_x); else passed++;
        total++; if (pass !== 1'b0) $display("FAIL cex_pass: got %b expected 0", pass); else passed++;
        total++; if (vac_cnt !== 9'd0) $display("FAIL cex_vac: got %0d expected 0", vac_cnt); else passed++;
    endtask

    task automatic test_stop_on_fail();
        int c;
        inv_a = 9'h02A; inv_b = 9'h100;
        run_sweep(1'b1, c);
        total++; if (c != 130) $display("FAIL sof_latency: got %0d expected 130", c); else passed++;
        @(negedge clk);
        total++; if (fail_cnt_sof !== 9'd1) $display("FAIL sof_fail_cnt: got %0d expected 1", fail_cnt_sof); else passed++;
        total++; if (x_sof !== 8'h2A || cex_x_sof !== 8'h2A) $display("FAIL sof_x: got x=%h cex=%h expected 2a/2a", x_sof, cex_x_sof); else passed++;
        total++; if (pass_sof !== 1'b0 || busy_sof !== 1'b0) $display("FAIL sof_pass_busy: got %b%b expected 00", pass_sof, busy_sof); else passed++;
    endtask

    task automatic test_vacuous();
        int c;
        inv_a = 9'h100; inv_b = 9'h100; spec_zero = 1'b1;
        run_sweep(1'b0, c);
        total++; if (c != 769) $display("FAIL vac_latency: got %0d expected 769", c); else passed++;
        @(negedge clk);
        total++; if (vac_cnt !== 9'd256) $display("FAIL vac_cnt: got %0d expected 256", vac_cnt); else passed++;
        total++; if (fail_cnt !== 9'd0 || pass !== 1'b1) $display("FAIL vac_verdict: got fail=%0d pass=%b expected 0/1", fail_cnt, pass); else passed++;
        spec_zero = 1'b0;
    endtask

    task automatic test_abort();
        int  n;
        bit  seen_done;
        inv_a = 9'h005; inv_b = 9'h100;
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (n == 50) start = 1'b1;
            if (n == 99) begin
                total++; if (x_out !== 8'd32 || busy !== 1'b1) $display("FAIL abort_ignore_start: got x=%0d busy=%b expected 32/1", x_out, busy); else passed++;
            end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_idle: got busy=%b done=%b expected 0/0", busy, done); else passed++;
        total++; if (pass !== 1'b0) $display("FAIL abort_pass: got %b expected 0", pass); else passed++;
        total++; if (fail_cnt !== 9'd1 || cex_x !== 8'h05 || x_out !== 8'd33) $display("FAIL abort_frozen: got fail=%0d cex=%h x=%0d expected 1/05/33", fail_cnt, cex_x, x_out); else passed++;
        seen_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0) seen_done = 1'b1;
        end
        total++; if (seen_done !== 1'b0) $display("FAIL abort_no_done: got %b expected 0", seen_done); else passed++;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        total++; if (busy !== 1'b0 || fail_cnt !== 9'd1) $display("FAIL abort_start_idle: got busy=%b fail=%0d expected 0/1", busy, fail_cnt); else passed++;
    endtask

    task automatic test_async_reset();
        int n, c;
        inv_a = 9'h000; inv_b = 9'h100;
        @(negedge clk);
        start = 1'b1;
        for (n = 0; n < 5; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        total++; if (y_out !== 1'b1 || fail_cnt !== 9'd1 || x_out !== 8'd1) $display("FAIL rst_pre_y1: got y=%b fail=%0d x=%0d expected 1/1/1", y_out, fail_cnt, x_out); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if ({busy, done, pass, cex_valid, y_out} !== 5'b0) $display("FAIL rst_async_flags: got %b expected 00000", {busy, done, pass, cex_valid, y_out}); else passed++;
        total++; if (x_out !== 8'h00 || fail_cnt !== 9'd0 || cex_x !== 8'h00) $display("FAIL rst_async_vals: got x=%h fail=%0d cex=%h expected 0/0/0", x_out, fail_cnt, cex_x); else passed++;
        @(negedge clk);
        rst = 1'b0;
        inv_a = 9'h100;
        run_sweep(1'b0, c);
        total++; if (c != 769) $display("FAIL rst_resweep_latency: got %0d expected 769", c); else passed++;
        @(negedge clk);
        total++; if (pass !== 1'b1 || fail_cnt !== 9'd0) $display("FAIL rst_resweep_pass: got pass=%b fail=%0d expected 1/0", pass, fail_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_counterexamples();
        test_stop_on_fail();
        test_vacuous();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
